// File: rtl/alu_result_stage.sv
// Registered ALU result stage with Z/N/C/V flags and a 2-entry skid buffer (valid/ready both sides).
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_result_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] result,
   input  logic             carry,
   input  logic             ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_z,
   output logic             out_n,
   output logic             out_c,
`ifdef ALU_STICKY_OVF_EN
   output logic             out_v,
   output logic             sticky_v,
   input  logic             clr_sticky
`else
   output logic             out_v
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

   occ_t             state;
   logic [WIDTH+3:0] in_entry;
   logic [WIDTH+3:0] main_q;
   logic [WIDTH+3:0] skid_q;
   logic             accept;
   logic             fire;

   // Entry layout: {result, Z, N, C, V}; flags are frozen at capture time.
   assign in_entry = {result, (result == '0), result[WIDTH-1], carry, ovf};

   assign accept = in_valid & in_ready;
   assign fire   = out_valid & out_ready;

   assign out_result = main_q[WIDTH+3:4];
   assign out_z      = main_q[3];
   assign out_n      = main_q[2];
   assign out_c      = main_q[1];
   assign out_v      = main_q[0];

   // in_ready comes up one edge after reset release and is otherwise !FULL, all registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               in_ready <= 1'b1;
               if (accept) begin
                  main_q    <= in_entry;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (accept && !fire) begin
                  skid_q   <= in_entry;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end else if (accept && fire) begin
                  main_q <= in_entry;
               end else if (fire) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (fire) begin
                  main_q   <= skid_q;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_STICKY_OVF_EN
   // Set has priority over clear when both land on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_v <= 1'b0;
      end else if (fire && main_q[0]) begin
         sticky_v <= 1'b1;
      end else if (clr_sticky) begin
         sticky_v <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; sticky checks build only with ALU_STICKY_OVF_EN.
module tb_alu_result_stage;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_z;
   logic             out_n;
   logic             out_c;
   logic             out_v;
`ifdef ALU_STICKY_OVF_EN
   logic             sticky_v;
   logic             clr_sticky;
`endif

   int checks = 0;
   int errors = 0;

   alu_result_stage #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .result     (result),
      .carry      (carry),
      .ovf        (ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_z      (out_z),
      .out_n      (out_n),
      .out_c      (out_c),
`ifdef ALU_STICKY_OVF_EN
      .out_v      (out_v),
      .sticky_v   (sticky_v),
      .clr_sticky (clr_sticky)
`else
      .out_v      (out_v)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (out_valid !== 1'b0 || out_result !== '0 || {out_z, out_n, out_c, out_v} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state: valid=%b result=%h zncv=%b%b%b%b required valid=0 result=0 zncv=0000",
                  out_valid, out_result, out_z, out_n, out_c, out_v);
      end
`ifdef ALU_STICKY_OVF_EN
      checks++;
      if (sticky_v !== 1'b0) begin
         errors++;
         $display("FAIL reset_sticky: got %b required 0", sticky_v);
      end
`endif
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      result    = 32'h0000_0000;
      carry     = 1'b1;
      ovf       = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h0 || {out_z, out_n, out_c, out_v} !== 4'b1010) begin
         errors++;
         $display("FAIL single_zero: valid=%b result=%h zncv=%b%b%b%b required 1 00000000 1010",
                  out_valid, out_result, out_z, out_n, out_c, out_v);
      end
      result = 32'h8000_0000;
      carry  = 1'b0;
      ovf    = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || {out_z, out_n, out_c, out_v} !== 4'b0101) begin
         errors++;
         $display("FAIL single_neg: valid=%b result=%h zncv=%b%b%b%b required 1 80000000 0101",
                  out_valid, out_result, out_z, out_n, out_c, out_v);
      end
      in_valid = 1'b0;
      ovf      = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      result    = 32'h11;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_result !== 32'h11) begin
         errors++;
         $display("FAIL bp_first: in_ready=%b result=%h required 1 00000011", in_ready, out_result);
      end
      result = 32'h22;
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_full: in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
      end
      result = 32'h33;
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_result !== 32'h11) begin
         errors++;
         $display("FAIL bp_hold: in_ready=%b result=%h required 0 00000011", in_ready, out_result);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_result !== 32'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: result=%h valid=%b in_ready=%b required 00000022 1 1",
                  out_result, out_valid, in_ready);
      end
      tick();
      checks++;
      if (out_result !== 32'h33 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_third: result=%h valid=%b required 00000033 1", out_result, out_valid);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_streaming();
      logic [WIDTH-1:0] r;
      logic             c;
      logic             v;
      logic [3:0]       exp_flags;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         r = $urandom;
         if (i == 10) r = 32'h0;
         if (i == 20) r = 32'h8000_0000;
         c = 1'($urandom_range(0, 1));
         v = 1'($urandom_range(0, 1));
         result = r;
         carry  = c;
         ovf    = v;
         tick();
         exp_flags = {(r == 32'h0), r[WIDTH-1], c, v};
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== r ||
             {out_z, out_n, out_c, out_v} !== exp_flags) begin
            errors++;
            $display("FAIL stream[%0d]: valid=%b rdy=%b result=%h zncv=%b%b%b%b required 1 1 %h %b",
                     i, out_valid, in_ready, out_result, out_z, out_n, out_c, out_v, r, exp_flags);
         end
      end
      in_valid = 1'b0;
      carry    = 1'b0;
      ovf      = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      result    = 32'hAA;
      tick();
      result = 32'hBB;
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_result !== 32'hAA) begin
         errors++;
         $display("FAIL mid_full: in_ready=%b result=%h required 0 000000aa", in_ready, out_result);
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_result !== '0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b result=%h required 0 00000000", out_valid, out_result);
      end
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_after[%0d]: valid=%b in_ready=%b required 0 1", i, out_valid, in_ready);
         end
      end
   endtask

`ifdef ALU_STICKY_OVF_EN
   task automatic test_sticky();
      out_ready  = 1'b1;
      in_valid   = 1'b0;
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if (sticky_v !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clear: got %b required 0", sticky_v);
      end
      in_valid = 1'b1;
      result   = 32'h5;
      ovf      = 1'b1;
      tick();
      ovf = 1'b0;
      for (int i = 0; i < 10; i++) begin
         result = 32'(i + 100);
         tick();
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (sticky_v !== 1'b1) begin
         errors++;
         $display("FAIL sticky_hold: got %b required 1", sticky_v);
      end
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if (sticky_v !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clr2: got %b required 0", sticky_v);
      end
      in_valid = 1'b1;
      result   = 32'h7;
      ovf      = 1'b1;
      tick();
      in_valid   = 1'b0;
      ovf        = 1'b0;
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if (sticky_v !== 1'b1) begin
         errors++;
         $display("FAIL sticky_set_wins: got %b required 1", sticky_v);
      end
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      result    = '0;
      carry     = 1'b0;
      ovf       = 1'b0;
      out_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
      clr_sticky = 1'b0;
`endif
      test_reset();
      test_single();
      test_backpressure();
      test_streaming();
      test_reset_mid();
`ifdef ALU_STICKY_OVF_EN
      test_sticky();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
